// File: rtl/case_pkg.sv
// Shared types and constants for the streaming ASCII case converter.
// Provides the per-frame mode encoding, the frame FSM state encoding,
// the ASCII letter range bounds and small range-test helpers.
package case_pkg;

    typedef enum logic [1:0] {
        CASE_PASS   = 2'b00,
        CASE_UPPER  = 2'b01,
        CASE_LOWER  = 2'b10,
        CASE_TOGGLE = 2'b11
    } mode_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_LZ = 8'h7A;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_UZ = 8'h5A;
    localparam int         CASE_BIT = 5;

    // True for 'a'..'z'
    function automatic logic is_lower(input logic [7:0] b);
        return (b >= ASCII_LA) && (b <= ASCII_LZ);
    endfunction

    // True for 'A'..'Z'
    function automatic logic is_upper(input logic [7:0] b);
        return (b >= ASCII_UA) && (b <= ASCII_UZ);
    endfunction

endpackage

// File: rtl/case_lane.sv
// Combinational single-byte case converter. Only bit 5 of an ASCII letter
// is ever touched; every other byte (including >= 0x80) passes unchanged.
// A lane whose keep bit is low outputs 0x00 and never reports a change.
module case_lane
    import case_pkg::*;
(
    input  logic [7:0] byte_i,
    input  mode_t      mode_i,
    input  logic       keep_i,
    output logic [7:0] byte_o,
    output logic       changed_o
);

    logic [7:0] conv_s;

    // Apply the selected mode to the byte, touching only the case bit
    always_comb begin
        conv_s = byte_i;
        case (mode_i)
            CASE_UPPER: begin
                if (is_lower(byte_i)) conv_s[CASE_BIT] = 1'b0;
                else                  conv_s = byte_i;
            end
            CASE_LOWER: begin
                if (is_upper(byte_i)) conv_s[CASE_BIT] = 1'b1;
                else                  conv_s = byte_i;
            end
            CASE_TOGGLE: begin
                if (is_lower(byte_i) || is_upper(byte_i)) conv_s[CASE_BIT] = ~byte_i[CASE_BIT];
                else                                       conv_s = byte_i;
            end
            default: conv_s = byte_i;
        endcase
    end

    assign byte_o    = keep_i ? conv_s : 8'h00;
    assign changed_o = keep_i & (conv_s != byte_i);

endmodule

// File: rtl/case_convert_stream.sv
// Streaming multi-lane ASCII case converter with a circular output FIFO.
// Mode is taken from the port on the first beat of a frame and held for the
// rest of it; single-beat frames use the port mode directly.
// Optional feature macro: CASE_CONVERT_STATS_EN adds saturating counters
// stat_conv (changed bytes) and stat_frames (accepted last beats).
module case_convert_stream
    import case_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int BUF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*8-1:0]   in_data,
    input  logic [LANES-1:0]     in_keep,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*8-1:0]   out_data,
    output logic [LANES-1:0]     out_keep,
    output logic                 out_last
`ifdef CASE_CONVERT_STATS_EN
    ,
    output logic [31:0]          stat_conv,
    output logic [15:0]          stat_frames
`endif
);

    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    state_t               state_q, state_d;
    mode_t                mode_q, mode_d;
    mode_t                eff_mode_s;
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 push_s, pop_s;
    logic [LANES*8-1:0]   conv_data_s;
    logic [LANES-1:0]     changed_s;
    logic [LANES*8-1:0]   data_mem_q [BUF_DEPTH];
    logic [LANES-1:0]     keep_mem_q [BUF_DEPTH];
    logic                 last_mem_q [BUF_DEPTH];

    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != {CW{1'b0}});
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;
    assign out_data  = data_mem_q[rd_ptr_q];
    assign out_keep  = keep_mem_q[rd_ptr_q];
    assign out_last  = last_mem_q[rd_ptr_q];

    // Mid-frame beats use the latched mode; a beat arriving in IDLE uses the port
    assign eff_mode_s = (state_q == ST_IDLE) ? mode_t'(mode) : mode_q;

    genvar g;
    for (g = 0; g < LANES; g++) begin : g_lane
        case_lane u_lane (
            .byte_i    (in_data[8*g +: 8]),
            .mode_i    (eff_mode_s),
            .keep_i    (in_keep[g]),
            .byte_o    (conv_data_s[8*g +: 8]),
            .changed_o (changed_s[g])
        );
    end

    // Frame FSM next state and mode latch on each accepted beat
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        if (push_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (!in_last) begin
                        state_d = ST_FRAME;
                        mode_d  = mode_t'(mode);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FRAME: begin
                    if (in_last) state_d = ST_IDLE;
                    else         state_d = ST_FRAME;
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FIFO occupancy: simultaneous push and pop leave the count unchanged
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Control registers: FSM, latched mode, pointers and count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= CASE_PASS;
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            count_q  <= count_d;
            if (push_s) wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            if (pop_s)  rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end
    end

    // FIFO storage: converted beat is written at accept; cleared on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                data_mem_q[i] <= {(LANES*8){1'b0}};
                keep_mem_q[i] <= {LANES{1'b0}};
                last_mem_q[i] <= 1'b0;
            end
        end else if (push_s) begin
            data_mem_q[wr_ptr_q] <= conv_data_s;
            keep_mem_q[wr_ptr_q] <= in_keep;
            last_mem_q[wr_ptr_q] <= in_last;
        end
    end

`ifdef CASE_CONVERT_STATS_EN
    logic [4:0]  conv_inc_s;
    logic [32:0] conv_sum_s;
    logic [31:0] stat_conv_q;
    logic [15:0] stat_frames_q;

    // Number of lanes in the accepted beat whose byte changed
    always_comb begin
        conv_inc_s = 5'd0;
        for (int i = 0; i < LANES; i++) begin
            conv_inc_s = conv_inc_s + {4'd0, changed_s[i]};
        end
        conv_sum_s = {1'b0, stat_conv_q} + {28'd0, conv_inc_s};
    end

    // Saturating statistics counters, updated at input accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_conv_q   <= 32'd0;
            stat_frames_q <= 16'd0;
        end else if (push_s) begin
            stat_conv_q <= conv_sum_s[32] ? 32'hFFFF_FFFF : conv_sum_s[31:0];
            if (in_last && (stat_frames_q != 16'hFFFF)) stat_frames_q <= stat_frames_q + 16'd1;
        end
    end

    assign stat_conv   = stat_conv_q;
    assign stat_frames = stat_frames_q;
`endif

endmodule

// File: tb/tb_case_convert_stream.sv
// Self-checking bench for case_convert_stream (LANES=4, BUF_DEPTH=4).
// Directed literal checks plus randomized traffic checked against a
// queue-based reference model by a single per-cycle compare process.
module tb_case_convert_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic [3:0]  in_keep = 4'd0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
`ifdef CASE_CONVERT_STATS_EN
    logic [31:0] stat_conv;
    logic [15:0] stat_frames;
`endif

    case_convert_stream #(.LANES(4), .BUF_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_keep(in_keep), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last)
`ifdef CASE_CONVERT_STATS_EN
        , .stat_conv(stat_conv), .stat_frames(stat_frames)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t q[$];
    bit    m_in_frame = 1'b0;
    int    m_fmode = 0;
    longint m_conv = 0;
    int    m_frames = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference conversion of one byte, by plain letter arithmetic
    function automatic logic [7:0] ref_byte(input logic [7:0] b, input int m);
        bit lo, up;
        lo = (b >= 8'd97) && (b <= 8'd122);
        up = (b >= 8'd65) && (b <= 8'd90);
        case (m)
            1:       return lo ? b - 8'd32 : b;
            2:       return up ? b + 8'd32 : b;
            3:       return lo ? b - 8'd32 : (up ? b + 8'd32 : b);
            default: return b;
        endcase
    endfunction

    // Per-cycle compare against the model; model updated at each edge
    initial begin
        bit    do_push, do_pop;
        beat_t nb;
        int    em, nchg;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                m_in_frame = 1'b0;
                m_conv = 0;
                m_frames = 0;
            end else begin
                chk(in_ready === (q.size() < 4), "in_ready", in_ready, q.size() < 4);
                chk(out_valid === (q.size() != 0), "out_valid", out_valid, q.size() != 0);
                if (out_valid && q.size() != 0) begin
                    chk(out_data === q[0].d, "out_data", out_data, q[0].d);
                    chk(out_keep === q[0].k, "out_keep", out_keep, q[0].k);
                    chk(out_last === q[0].l, "out_last", out_last, q[0].l);
                end
                do_push = in_valid && in_ready;
                do_pop  = out_valid && out_ready && (q.size() != 0);
                nchg = 0;
                if (do_push) begin
                    em = m_in_frame ? m_fmode : int'(mode);
                    for (int i = 0; i < 4; i++) begin
                        logic [7:0] b, r;
                        b = in_data[8*i +: 8];
                        r = ref_byte(b, em);
                        nb.d[8*i +: 8] = in_keep[i] ? r : 8'h00;
                        if (in_keep[i] && r != b) nchg++;
                    end
                    nb.k = in_keep;
                    nb.l = in_last;
                    if (!m_in_frame && !in_last) begin
                        m_in_frame = 1'b1;
                        m_fmode = int'(mode);
                    end else if (m_in_frame && in_last) begin
                        m_in_frame = 1'b0;
                    end
                end
                @(posedge clk);
                if (!rst) begin
                    if (do_pop) void'(q.pop_front());
                    if (do_push) begin
                        q.push_back(nb);
                        m_conv += nchg;
                        if (nb.l) m_frames++;
                    end
                end else begin
                    q.delete();
                    m_in_frame = 1'b0;
                    m_conv = 0;
                    m_frames = 0;
                end
            end
        end
    end

    // Offer one beat and hold it until accepted (bounded)
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [1:0] m);
        bit ok;
        in_data = d; in_keep = k; in_last = l; mode = m; in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk(ok, "accept_timeout", ok, 1'b1);
    endtask

    task automatic expect_out(input string nm, input logic [31:0] d, input logic [3:0] k, input logic l);
        chk(out_valid === 1'b1, {nm, "_valid"}, out_valid, 1'b1);
        chk(out_data === d, {nm, "_data"}, out_data, d);
        chk(out_keep === k, {nm, "_keep"}, out_keep, k);
        chk(out_last === l, {nm, "_last"}, out_last, l);
    endtask

    function automatic logic [7:0] rnd_byte();
        case ($urandom_range(0, 3))
            0:       return 8'($urandom_range(8'h41, 8'h5A));
            1:       return 8'($urandom_range(8'h61, 8'h7A));
            2:       return 8'($urandom_range(8'h3E, 8'h7E));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        bit done;
        // Pin the reference model with hand-computed values
        chk(ref_byte(8'h61, 1) == 8'h41, "model_upper", ref_byte(8'h61, 1), 8'h41);
        chk(ref_byte(8'h5B, 2) == 8'h5B, "model_lower_edge", ref_byte(8'h5B, 2), 8'h5B);
        chk(ref_byte(8'h47, 3) == 8'h67, "model_toggle", ref_byte(8'h47, 3), 8'h67);
        chk(ref_byte(8'hEB, 3) == 8'hEB, "model_high", ref_byte(8'hEB, 3), 8'hEB);

        // Reset state
        #12;
        chk(out_valid === 1'b0, "rst_out_valid", out_valid, 1'b0);
        chk(out_data === 32'd0, "rst_out_data", out_data, 32'd0);
        chk(out_keep === 4'd0, "rst_out_keep", out_keep, 4'd0);
        chk(out_last === 1'b0, "rst_out_last", out_last, 1'b0);
        chk(in_ready === 1'b1, "rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Directed conversions (one-cycle latency with empty FIFO)
        out_ready = 1'b1;
        send(32'h7A487B61, 4'hF, 1'b1, 2'b01);
        expect_out("upper", 32'h5A487B41, 4'hF, 1'b1);
        send(32'h5B5A4140, 4'hF, 1'b1, 2'b10);
        expect_out("lower", 32'h5B7A6140, 4'hF, 1'b1);
        send(32'h5B5A4140, 4'h5, 1'b1, 2'b10);
        expect_out("lower_keep", 32'h007A0040, 4'h5, 1'b1);
        send(32'h476D83EB, 4'hF, 1'b1, 2'b11);
        expect_out("toggle", 32'h674D83EB, 4'hF, 1'b1);

        // Mode latch across a two-beat frame, then re-sample on next frame
        send(32'h6D6D6D6D, 4'hF, 1'b0, 2'b01);
        expect_out("latch_b1", 32'h4D4D4D4D, 4'hF, 1'b0);
        send(32'h6D6D6D6D, 4'hF, 1'b1, 2'b10);
        expect_out("latch_b2", 32'h4D4D4D4D, 4'hF, 1'b1);
        send(32'h4D4D4D4D, 4'hF, 1'b1, 2'b10);
        expect_out("latch_next", 32'h6D6D6D6D, 4'hF, 1'b1);
        repeat (2) @(posedge clk); #1;

        // Backpressure: four beats fill the FIFO, fifth waits
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h61616161 + 32'(i), 4'hF, 1'b1, 2'b01);
        chk(in_ready === 1'b0, "full_in_ready", in_ready, 1'b0);
        expect_out("full_head", 32'h41414141, 4'hF, 1'b1);
        fork
            begin repeat (3) @(posedge clk); #1; out_ready = 1'b1; end
            send(32'h65656565, 4'hF, 1'b1, 2'b01);
        join
        repeat (6) @(posedge clk); #1;

        // Asynchronous reset with three entries buffered mid-frame
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h61626364, 4'hF, 1'b0, 2'b01);
        #2; rst = 1'b1; #1;
        chk(out_valid === 1'b0, "async_rst_valid", out_valid, 1'b0);
        chk(out_data === 32'd0, "async_rst_data", out_data, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        out_ready = 1'b1;
`ifdef CASE_CONVERT_STATS_EN
        chk(stat_conv === 32'd0, "stat_conv_rst", stat_conv, 32'd0);
        chk(stat_frames === 16'd0, "stat_frames_rst", stat_frames, 16'd0);
        send(32'h41616161, 4'hF, 1'b1, 2'b01);
        send(32'h61414141, 4'hF, 1'b1, 2'b10);
        chk(stat_conv === 32'd6, "stat_conv_6", stat_conv, 32'd6);
        chk(stat_frames === 16'd2, "stat_frames_2", stat_frames, 16'd2);
`endif
        send(32'h41414141, 4'hF, 1'b0, 2'b10);
        expect_out("resample_b1", 32'h61616161, 4'hF, 1'b0);
        send(32'h41414141, 4'hF, 1'b1, 2'b01);
        expect_out("resample_b2", 32'h61616161, 4'hF, 1'b1);
        repeat (2) @(posedge clk); #1;

        // Randomized traffic with random consumer backpressure
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    logic [31:0] d;
                    for (int i = 0; i < 4; i++) d[8*i +: 8] = rnd_byte();
                    send(d, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0),
                         2'($urandom_range(0, 3)));
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        repeat (10) @(posedge clk); #1;
        chk(out_valid === 1'b0, "drain_empty", out_valid, 1'b0);
`ifdef CASE_CONVERT_STATS_EN
        chk(stat_conv === 32'(m_conv), "stat_conv_rand", stat_conv, m_conv);
        chk(stat_frames === 16'(m_frames), "stat_frames_rand", stat_frames, m_frames);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
